// File: rtl/johnson_phase_decoder.sv
// Decodes a Johnson counter code into a one-hot/binary phase, checks legality and
// sequencing, tracks lock with a three-state FSM and counts locked revolutions.
module johnson_phase_decoder #(
  parameter int WIDTH = 4,
  parameter int REV_W = 16,
  parameter int IDX_W = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   count_in,
  input  logic               count_vld,
  input  logic               clear_err,
  output logic [2*WIDTH-1:0] phase_onehot,
  output logic [IDX_W-1:0]   phase_idx,
  output logic               phase_vld,
  output logic               locked,
  output logic               err_illegal,
  output logic               err_seq,
  output logic               err_sticky,
  output logic [REV_W-1:0]   rev_count
);
  localparam int P = 2*WIDTH;

  typedef enum logic [1:0] {S_UNLOCKED, S_ACQUIRE, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IDX_W:0]   run_q, run_d;
  logic [P-1:0]     onehot_q, onehot_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             locked_q, locked_d;
  logic             err_il_q, err_il_d;
  logic             err_seq_q, err_seq_d;
  logic             sticky_q, sticky_d;
  logic [REV_W-1:0] rev_q, rev_d;

  logic             dec_legal;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] idx_succ;
  logic             in_seq;

  // Code for phase k: k ones from the MSB for k<=WIDTH, else P-k ones from the LSB.
  function automatic logic [WIDTH-1:0] jcode(input int k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= WIDTH) jcode = ~(ones >> k);
    else            jcode = ones >> (k - WIDTH);
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_idx   = '0;
    for (int k = 0; k < P; k++) begin
      if (count_in == jcode(k)) begin
        dec_legal = 1'b1;
        dec_idx   = IDX_W'(k);
      end
    end
  end

  // idx_q always holds the last legal phase, so it doubles as the successor anchor.
  assign idx_succ = (idx_q == IDX_W'(P-1)) ? '0 : idx_q + 1'b1;
  assign in_seq   = (dec_idx == idx_succ);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    onehot_d  = onehot_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    err_il_d  = 1'b0;
    err_seq_d = 1'b0;
    rev_d     = rev_q;
    if (count_vld) begin
      if (!dec_legal) begin
        vld_d    = 1'b0;
        onehot_d = '0;
        err_il_d = 1'b1;
        state_d  = S_UNLOCKED;
        run_d    = '0;
      end else begin
        vld_d    = 1'b1;
        idx_d    = dec_idx;
        onehot_d = {{(P-1){1'b0}}, 1'b1} << dec_idx;
        case (state_q)
          S_UNLOCKED: begin
            state_d = S_ACQUIRE;
            run_d   = '0;
          end
          S_ACQUIRE: begin
            if (in_seq) begin
              run_d = run_q + 1'b1;
              if (run_q == (IDX_W+1)'(P-1)) state_d = S_LOCKED;
            end else begin
              err_seq_d = 1'b1;
              run_d     = '0;
            end
          end
          S_LOCKED: begin
            if (in_seq) begin
              if (idx_q == IDX_W'(P-1)) rev_d = rev_q + 1'b1;
            end else begin
              err_seq_d = 1'b1;
              state_d   = S_ACQUIRE;
              run_d     = '0;
            end
          end
          default: begin
            state_d = S_UNLOCKED;
            run_d   = '0;
          end
        endcase
      end
    end
    locked_d = (state_d == S_LOCKED);
    // A fresh error beats a coincident clear.
    if (err_il_d || err_seq_d) sticky_d = 1'b1;
    else if (clear_err)        sticky_d = 1'b0;
    else                       sticky_d = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_UNLOCKED;
      run_q     <= '0;
      onehot_q  <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_il_q  <= 1'b0;
      err_seq_q <= 1'b0;
      sticky_q  <= 1'b0;
      rev_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      locked_q  <= locked_d;
      err_il_q  <= err_il_d;
      err_seq_q <= err_seq_d;
      sticky_q  <= sticky_d;
      rev_q     <= rev_d;
    end
  end

  assign phase_onehot = onehot_q;
  assign phase_idx    = idx_q;
  assign phase_vld    = vld_q;
  assign locked       = locked_q;
  assign err_illegal  = err_il_q;
  assign err_seq      = err_seq_q;
  assign err_sticky   = sticky_q;
  assign rev_count    = rev_q;

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the Johnson counter's `count` bus. It decodes each sampled Johnson code into a one-hot phase and a binary phase index, and checks that codes are legal and advance strictly in sequence. A lock state machine reports when the counter is tracking cleanly, and a revolution counter reports completed cycles. The one-hot phase outputs drive downstream multi-phase timing and enable logic.

## Interface
- `WIDTH`, 4, Johnson counter width (≥2); the number of phases is P = 2·WIDTH.
- `REV_W`, 16, width of the revolution counter.
- `IDX_W`, $clog2(2·WIDTH), width of the phase index.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `count_in`  in  WIDTH  Johnson code from the upstream counter.
- `count_vld`  in  1  qualifies `count_in`; the block samples only when this is high.
- `clear_err`  in  1  clears `err_sticky`.
- `phase_onehot`  out  P  registered one-hot phase; all-zero when no legal phase is held.
- `phase_idx`  out  IDX_W  registered phase index.
- `phase_vld`  out  1  `phase_onehot` and `phase_idx` hold a legal decode.
- `locked`  out  1  high while the FSM is in LOCKED.
- `err_illegal`  out  1  one-cycle pulse when an illegal code is sampled.
- `err_seq`  out  1  one-cycle pulse when a legal but out-of-sequence code is sampled.
- `err_sticky`  out  1  sticky OR of both error pulses.
- `rev_count`  out  REV_W  count of completed revolutions while locked; wraps.

## Operation
- **Phase decode.**
  - k ones packed from the MSB down, with zeros below (k = 0..WIDTH), decodes to phase k.
  - k ones packed from the LSB up, with zeros above (k = 1..WIDTH−1), decodes to phase P−k.
  - Any other pattern is illegal.
  - Example for WIDTH=4: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
- **Legal sample.** Sets `phase_vld`=1, `phase_idx`=k and `phase_onehot`=1<<k.
- **Illegal sample.** Sets `phase_vld`=0 and `phase_onehot`=0. `phase_idx` holds its previous value. `err_illegal` pulses.
- **No sample.** When `count_vld`=0, all outputs hold and there are no pulses. The successor check compares against the last sampled phase, however many cycles ago it was sampled.
- **Successor rule.** A sample is in sequence when its phase equals (previous phase + 1) mod P. Phase P−1 → 0 is a legal wrap.
- **FSM states:** UNLOCKED, ACQUIRE, LOCKED. There is a run counter `run` of width IDX_W+1.
  - UNLOCKED:
    - Legal sample → ACQUIRE, with `run`=0.
    - Illegal sample → stay in UNLOCKED.
  - ACQUIRE:
    - In-sequence sample → `run`+1. When `run` reaches P−1 on this sample (P consecutive good advances), move to LOCKED.
    - Legal, out-of-sequence sample → `err_seq` pulses; stay in ACQUIRE with `run`=0, re-anchored on the new phase.
    - Illegal sample → UNLOCKED.
  - LOCKED:
    - In-sequence sample → stay in LOCKED.
    - Out-of-sequence sample → `err_seq` pulses; go to ACQUIRE with `run`=0.
    - Illegal sample → UNLOCKED.
- **Revolution counter.**
  - Increments only in LOCKED, on an in-sequence P−1 → 0 transition.
  - Wraps from 2^REV_W−1 to 0.
  - Holds its value when the FSM leaves LOCKED; only `reset` clears it.
- **Sticky error.**
  - `err_sticky` is set by either error pulse and cleared by `clear_err`.
  - If a new error and `clear_err` occur in the same cycle, the error wins and `err_sticky` stays 1.

## Timing
- **Latency.** Sampling `count_in` on edge n updates all outputs after edge n. They are visible in cycle n+1, which is one cycle of latency. Every output is registered.
- **Error pulses.** Each pulse is exactly one cycle wide and is coincident with the decoded outputs of the offending sample.
- **Back-to-back samples.** Samples on consecutive cycles are fully supported, with throughput of one sample per clock.
- **Reset values.** `reset` wins over every other input and sets:
  - `phase_onehot`=0, `phase_idx`=0, `phase_vld`=0;
  - `locked`=0, FSM in UNLOCKED, `run`=0;
  - all error outputs 0, `rev_count`=0.
- **Reset mid-run.** Asserting `reset` during LOCKED gives the reset values on the next cycle. The first legal sample after reset re-enters ACQUIRE.
- **LOCKED rise.** `locked` rises in the same cycle as the outputs of the P-th consecutive in-sequence sample.
- **LOCKED fall.** `locked` falls in the same cycle as the outputs of the first bad sample.

## Test plan
All scenarios use WIDTH=4.
- **Reset.** Hold `reset` high for 3 cycles → all outputs 0 and `locked`=0. Then apply 0000 with `count_vld`=1 → `phase_onehot`=0x01, `phase_idx`=0, `phase_vld`=1 on the next cycle.
- **Lock and revolutions.**
  - Stimulus: the continuous legal sequence from 0001, one sample per cycle.
  - `locked` rises on the 9th sample, the 8th in-sequence advance.
  - `rev_count` increments at each 0001→0000 while locked; it reads 3 after three further wraps.
- **Illegal code while locked.** Inject 0101 while locked → `err_illegal` pulses, `phase_vld`=0, `phase_onehot`=0, `phase_idx` unchanged, `locked`=0, `err_sticky`=1, and `rev_count` is retained.
- **Skipped phase.** While locked, sample 1100 then 1111 → `err_seq` pulses and the FSM goes to ACQUIRE. `locked` re-rises after 8 further good advances.
- **Gaps and clear.**
  - Gaps: sample 1000, hold `count_vld`=0 for 5 cycles, then sample 1100 → no `err_seq`, and the outputs hold during the gap.
  - Clear: after the previous error, assert `clear_err` → `err_sticky`=0.
  - Collision: `clear_err` coincident with a new error → `err_sticky` stays 1.
- **Counter wrap.** With REV_W=2, five locked revolutions → `rev_count` reads 1 (0→1→2→3→0→1).
